// File: rtl/sha3_block_loader.sv
// sha3_block_loader: assembles bus writes into a SHA3 rate block with valid/ready handoff.
// Optional SHA3_PAD_EN adds pad10*1 padding and an extra padding-only block when needed.
module sha3_block_loader #(
    parameter int                DATA_W    = 32,
    parameter int                MAX_WORDS = 1152 / DATA_W,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BLK_ADDR  = 'h55
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              write_e,
    input  logic [ADDR_W-1:0]                 addr_in,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic [1:0]                        mode,
    input  logic                              last,
    input  logic [$clog2(DATA_W/8):0]         last_bytes,
    output logic                              wr_ready,
    output logic [MAX_WORDS*DATA_W-1:0]       block_o,
    output logic                              block_valid,
    input  logic                              block_ready,
    output logic                              block_last,
    output logic [$clog2(MAX_WORDS+1)-1:0]    word_count,
    output logic                              overflow
);
    localparam int BPW   = DATA_W / 8;
    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam int BLK_W = MAX_WORDS * DATA_W;
`ifdef SHA3_PAD_EN
    typedef enum logic [1:0] {IDLE, FILL, FULL, PADBLK} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
`endif
    function automatic logic [WC_W-1:0] rate_of(input logic [1:0] m);
        return m == 2'd0 ? WC_W'(576 / DATA_W) :
               m == 2'd1 ? WC_W'(832 / DATA_W) :
               m == 2'd2 ? WC_W'(1088 / DATA_W) : WC_W'(1152 / DATA_W);
    endfunction
    state_t            state;
    logic [WC_W-1:0]   rate_q, rw;
    logic              hit, acc, done, pad_next;
    logic [BLK_W-1:0]  wr_vec, pad_vec;
    assign hit  = write_e && addr_in == BLK_ADDR;
    assign acc  = hit && wr_ready;
    assign rw   = state == IDLE ? rate_of(mode) : rate_q;
    assign done = acc && (last || word_count == rw - WC_W'(1));
    always_comb begin
        wr_vec = '0;
        wr_vec[int'(word_count)*DATA_W +: DATA_W] = data_in;
    end
`ifdef SHA3_PAD_EN
    logic             pad_pend;
    logic [BLK_W-1:0] padblk_vec;
    int               pos, rbytes;
    // 0x06 lands at byte offset last_bytes past the start of the final word; past the rate it spills into a pad block
    always_comb begin
        pad_vec    = '0;
        padblk_vec = '0;
        rbytes     = int'(rw) * BPW;
        pos        = int'(word_count) * BPW + int'(last_bytes);
        pad_next   = last && pos >= rbytes;
        if (last && !pad_next) begin
            pad_vec[pos*8 +: 8]        = 8'h06;
            pad_vec[(rbytes-1)*8 +: 8] = pad_vec[(rbytes-1)*8 +: 8] | 8'h80;
        end
        padblk_vec[7:0]               = 8'h06;
        padblk_vec[(rbytes-1)*8 +: 8] = 8'h80;
    end
`else
    logic unused_lb;
    assign unused_lb = ^last_bytes;
    assign pad_vec   = '0;
    assign pad_next  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            block_o     <= '0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            word_count  <= '0;
            overflow    <= 1'b0;
            wr_ready    <= 1'b1;
            rate_q      <= '0;
`ifdef SHA3_PAD_EN
            pad_pend    <= 1'b0;
`endif
        end else begin
            overflow <= hit && !wr_ready;
            case (state)
                IDLE, FILL: if (acc) begin
                    rate_q      <= rw;
                    block_o     <= block_o | wr_vec | pad_vec;
                    word_count  <= word_count + WC_W'(1);
                    state       <= done ? FULL : FILL;
                    block_valid <= done;
                    wr_ready    <= !done;
                    block_last  <= last && !pad_next;
`ifdef SHA3_PAD_EN
                    pad_pend    <= pad_next;
`endif
                end
                default: if (block_ready) begin
                    state       <= IDLE;
                    block_o     <= '0;
                    block_valid <= 1'b0;
                    block_last  <= 1'b0;
                    word_count  <= '0;
                    wr_ready    <= 1'b1;
`ifdef SHA3_PAD_EN
                    if (pad_pend) begin
                        state       <= PADBLK;
                        block_o     <= padblk_vec;
                        block_valid <= 1'b1;
                        block_last  <= 1'b1;
                        wr_ready    <= 1'b0;
                        pad_pend    <= 1'b0;
                    end
`endif
                end
            endcase
        end
    end
endmodule
